// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential multiply path.
//   state_t      : multiplier controller states (IDLE/RUN/DONE)
//   booth_op_t   : radix-2 Booth operation selected by {Q[0], q_1}
//   cnt_width()  : iteration counter width for an N-bit multiply
//   booth_decode : maps {Q[0], q_1} to a Booth operation
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_t;

    // The counter has to hold the value N itself, hence N+1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// W-bit two's-complement adder/subtractor.
//   a, b      : operands
//   sub       : 0 -> y = a + b, 1 -> y = a - b
//   y         : W-bit result
//   carry_out : carry out of the MSB (inverted borrow when subtracting)
//   overflow  : signed overflow of the W-bit result
module adder_subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         carry_out,
    output logic         overflow
);

    logic [W-1:0] b_eff;

    always_comb begin
        b_eff               = b ^ {W{sub}};
        {carry_out, y}      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
        overflow            = (a[W-1] == b_eff[W-1]) && (y[W-1] != a[W-1]);
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, N-bit signed operands, 2N-bit product.
// One iteration per clock; result after N iterations.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a multiply (ignored while busy)
//   a, b       : signed multiplicand / multiplier, sampled on an accepted start
//   busy       : high during the N iteration cycles
//   done       : one-cycle pulse when product is updated
//   product    : signed result, held until the next completion
module booth_multiplier
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CNT_W = cnt_width(N);

    state_t           state, state_next;
    logic [N:0]       m_reg, acc, addsub_y, acc_upd, acc_sh;
    logic [N-1:0]     q_reg, q_sh;
    logic             q_1, q_1_sh;
    logic [CNT_W-1:0] cnt;
    booth_op_t        op;
    logic             accept, last_iter;
    logic             unused_carry, unused_ovf;

    assign op = booth_decode(q_reg[0], q_1);

    // N+1-bit datapath: A +/- M cannot overflow even for M = -2^(N-1).
    adder_subtractor #(.W(N + 1)) u_addsub (
        .a         (acc),
        .b         (m_reg),
        .sub       (op == BOOTH_SUB),
        .y         (addsub_y),
        .carry_out (unused_carry),
        .overflow  (unused_ovf)
    );

    // Arithmetic right shift of {A', Q, q_1}.
    always_comb begin
        acc_upd = (op == BOOTH_NOP) ? acc : addsub_y;
        acc_sh  = {acc_upd[N], acc_upd[N:1]};
        q_sh    = {acc_upd[0], q_reg[N-1:1]};
        q_1_sh  = q_reg[0];
    end

    assign accept    = start && (state != RUN);
    assign last_iter = (state == RUN) && (cnt == CNT_W'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            acc     <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m_reg <= {a[N-1], a};
            acc   <= '0;
            q_reg <= b;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(N);
        end else if (state == RUN) begin
            acc   <= acc_sh;
            q_reg <= q_sh;
            q_1   <= q_1_sh;
            cnt   <= cnt - CNT_W'(1);
            if (last_iter) product <= {acc_sh[N-1:0], q_sh};
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential radix-2 Booth multiplier for N-bit two's-complement operands, producing a 2N-bit signed product after N iteration cycles. It is the sequential controller directly upstream of the existing `adder_subtractor`. Each cycle it drives that block's `a`, `b` and `sub` inputs and registers its `y` output back into the partial-product accumulator. It serves as the multiply path beside the add/sub datapath.

## Interface
- `N`, default 8: operand width in bits; must be ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a multiply; sampled on the rising edge; accepted only when not in RUN.
- `a` input N: signed multiplicand; sampled with an accepted `start`.
- `b` input N: signed multiplier; sampled with an accepted `start`.
- `busy` output 1: high while iterating (RUN state).
- `done` output 1: one-cycle pulse marking a valid new `product`.
- `product` output 2N: signed result; held until the next completion.

## Operation
- Registers:
  - M: N+1 bits, sign-extended `a`.
  - A: N+1 bits, accumulator.
  - Q: N bits.
  - q_1: 1 bit.
  - cnt: counts N down to 0.
  - product: 2N bits.
  - state.
- States and transitions:
  - IDLE: `start` goes to RUN.
  - RUN: when cnt reaches 1 and the last iteration completes, go to DONE.
  - DONE: `start` goes to RUN; otherwise IDLE.
- Accept (IDLE or DONE with `start`=1): M←sext(`a`), Q←`b`, A←0, q_1←0, cnt←N.
- RUN iteration, selected by {Q[0], q_1}:
  - 01: A'=A+M (sub=0).
  - 10: A'=A−M (sub=1).
  - 00 or 11: A'=A.
  - Then arithmetic-shift {A',Q,q_1} right by one: A's MSB is replicated, A'[0]→Q[N−1], Q[0]→q_1. Decrement cnt.
- The add/sub operates at N+1 bits, so A never overflows, including M=−2^(N−1) under subtraction. Carry/overflow from the adder are ignored.
- On the final iteration, product←low 2N bits of the shifted {A,Q}, i.e. {A'[N−1:0], Q'} after the shift. Move to DONE.
- `start` while in RUN is ignored: operands are not re-sampled and the current run is not disturbed.
- `product` changes only on entry to DONE; it is stable at all other times.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0. Asserting reset mid-RUN aborts the operation; no `done` is produced.
- `start` accepted at edge t0:
  - `busy`=1 for cycles t0+1 … t0+N.
  - `done`=1 and new `product` visible in cycle t0+N+1.
  - Latency is N+1 cycles from the accept edge to `done`.
- Back-to-back: `start`=1 during the DONE cycle is accepted at that edge. RUN begins the next cycle, giving throughput of one result per N+1 cycles.
- `busy` and `done` are registered state decodes, mutually exclusive, never both high.
- After reset release, the first `start` is sampled at the first rising edge with `rst_n`=1.

## Structure
- Shared package `arith_pkg` holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - Booth op decode constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - counter width `CNT_W = $clog2(N+1)`.
- One sub-module: `adder_subtractor #(N+1)` instantiated as `u_addsub`.
  - Inputs: `a`=A, `b`=M, `sub` from the Booth decode.
  - `y` feeds the shift logic; `carry_out` and `overflow` are left unconnected.
- All remaining logic is local: FSM, counter, shifter, product register.

## Test plan
- N=8, `a`=3, `b`=5, `start` pulse → `busy` high for 8 cycles; `done` at t0+9; `product`=16'h000F.
- `a`=−3 (8'hFD), `b`=5 → `product`=16'hFFF1. `a`=7, `b`=−1 → 16'hFFF9.
- Corner values:
  - `a`=−128, `b`=−128 → 16'h4000.
  - `a`=−128, `b`=127 → 16'hC080.
  - `a`=127, `b`=127 → 16'h3F01.
  - `a`=0, `b`=8'hA5 → 16'h0000.
- `start` with a=2, b=2, then during RUN `start`=1 with a=9, b=9 → ignored; a single `done` with `product`=16'h0004.
- Back-to-back:
  - `start` held high through the DONE cycle with new operands a=4, b=−4.
  - First `done` shows the prior result.
  - Second `done` arrives exactly N+1 cycles later with 16'hFFF0.
- `rst_n` pulsed low at t0+4 mid-run → immediately `busy`=0, `done`=0, `product`=0. No `done` afterwards until a new `start`, which then completes normally.
